// File: rtl/fullscreen_sprite_fader.sv
// rtl/fullscreen_sprite_fader.sv - scales a sprite ROM to full screen with screen-change fades (SCREEN_FADE_EN)
module fullscreen_sprite_fader #(
    parameter int SRC_W       = 160,
    parameter int SRC_H       = 120,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int NUM_SCREENS = 4,
    parameter int FADE_FRAMES = 2,
    localparam int ADDR_W     = $clog2(SRC_W * SRC_H),
    localparam int SEL_W      = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              req_valid,
    input  logic [SEL_W-1:0]  req_screen,
    output logic              req_ready,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [SEL_W-1:0]  rom_sel,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
);

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWITCH, FADE_IN} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] cur_screen, cur_nxt;
    logic [SEL_W-1:0] pending, pend_nxt;
    logic [SEL_W-1:0] req_clamped;
    logic             done_nxt;
    logic             frame_tick;
    logic             blank_d1, blank_d2;
    logic [31:0]      x_term, y_term;

    assign frame_tick  = (DrawX == 10'd0) && (32'(DrawY) == SCREEN_H);
    assign req_clamped = (32'(req_screen) >= NUM_SCREENS) ? SEL_W'(NUM_SCREENS - 1) : req_screen;
    assign rom_sel     = cur_screen;

`ifdef SCREEN_FADE_EN
    localparam int FC_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    logic [FC_W-1:0] fcnt;
    logic [3:0]      level, level_nxt;
    logic            step, fcnt_clr;

    assign step = frame_tick && (32'(fcnt) == FADE_FRAMES - 1);
`endif

    always_comb begin
        x_term = (32'(DrawX) * 32'(SRC_W)) / 32'(SCREEN_W);
        y_term = ((32'(DrawY) * 32'(SRC_H)) / 32'(SCREEN_H)) * 32'(SRC_W);
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_screen;
        pend_nxt  = pending;
        done_nxt  = 1'b0;
        req_ready = (state == IDLE);
`ifdef SCREEN_FADE_EN
        level_nxt = level;
        fcnt_clr  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_clamped == cur_screen) begin
                        done_nxt = 1'b1;
                    end else begin
                        pend_nxt = req_clamped;
`ifdef SCREEN_FADE_EN
                        state_nxt = FADE_OUT;
                        fcnt_clr  = 1'b1;
`else
                        state_nxt = SWITCH;
`endif
                    end
                end
            end
`ifdef SCREEN_FADE_EN
            FADE_OUT: begin
                if (step) begin
                    if (level <= 4'd1) begin
                        level_nxt = 4'd0;
                        state_nxt = SWITCH;
                    end else begin
                        level_nxt = level - 4'd1;
                    end
                end
            end
            FADE_IN: begin
                if (step) begin
                    if (level >= 4'd14) begin
                        level_nxt = 4'd15;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        level_nxt = level + 4'd1;
                    end
                end
            end
`endif
            SWITCH: begin
                // the image only changes during vertical blank
                if (frame_tick) begin
                    cur_nxt = pending;
`ifdef SCREEN_FADE_EN
                    state_nxt = FADE_IN;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur_screen <= '0;
            pending    <= '0;
            done       <= 1'b0;
`ifdef SCREEN_FADE_EN
            level      <= 4'd15;
            fcnt       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cur_screen <= cur_nxt;
            pending    <= pend_nxt;
            done       <= done_nxt;
`ifdef SCREEN_FADE_EN
            level      <= level_nxt;
            if (fcnt_clr)
                fcnt <= '0;
            else if (frame_tick)
                fcnt <= step ? '0 : fcnt + 1'b1;
`endif
        end
    end

    // address -> ROM data -> palette -> colour register: three cycles, blank follows in step
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            blank_d1 <= 1'b0;
            blank_d2 <= 1'b0;
            red      <= 4'd0;
            green    <= 4'd0;
            blue     <= 4'd0;
        end else begin
            rom_addr <= ADDR_W'(x_term + y_term);
            blank_d1 <= blank;
            blank_d2 <= blank_d1;
            if (!blank_d2) begin
                red   <= 4'd0;
                green <= 4'd0;
                blue  <= 4'd0;
            end else begin
`ifdef SCREEN_FADE_EN
                red   <= 4'(({4'd0, pal_red}   * ({4'd0, level} + 8'd1)) >> 4);
                green <= 4'(({4'd0, pal_green} * ({4'd0, level} + 8'd1)) >> 4);
                blue  <= 4'(({4'd0, pal_blue}  * ({4'd0, level} + 8'd1)) >> 4);
`else
                red   <= pal_red;
                green <= pal_green;
                blue  <= pal_blue;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fullscreen_sprite_fader.sv
// tb/tb_fullscreen_sprite_fader.sv - scoreboard bench for fullscreen_sprite_fader (either SCREEN_FADE_EN build)
module tb_fullscreen_sprite_fader;

    localparam int SRC_W       = 160;
    localparam int SRC_H       = 120;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int NUM_SCREENS = 6;
    localparam int FADE_FRAMES = 2;
    localparam int ADDR_W      = $clog2(SRC_W * SRC_H);
    localparam int SEL_W       = $clog2(NUM_SCREENS);

    logic              vga_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [9:0]        DrawX = '0, DrawY = '0;
    logic              blank = 1'b0, req_valid = 1'b0;
    logic [SEL_W-1:0]  req_screen = '0;
    logic              req_ready, done;
    logic [ADDR_W-1:0] rom_addr;
    logic [SEL_W-1:0]  rom_sel;
    logic [3:0]        pal_red, pal_green, pal_blue, red, green, blue;
    logic [7:0]        rom_q;

    fullscreen_sprite_fader #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
        .NUM_SCREENS(NUM_SCREENS), .FADE_FRAMES(FADE_FRAMES)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .req_valid(req_valid), .req_screen(req_screen), .req_ready(req_ready), .done(done),
        .rom_addr(rom_addr), .rom_sel(rom_sel),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [7:0] rom_fn(input int sel, input int addr);
        return 8'((sel * 37) + (addr * 13) + (addr >> 5));
    endfunction

    function automatic int scale(input int p, input int lvl);
        return (p * (lvl + 1)) / 16;
    endfunction

    always @(posedge vga_clk) rom_q <= rom_fn(int'(rom_sel), int'(rom_addr));
    assign pal_red   = rom_q[3:0];
    assign pal_green = rom_q[7:4];
    assign pal_blue  = rom_q[3:0] ^ rom_q[7:4];

    typedef struct { int due; int rgb; } pix_t;
    typedef struct { int due; int addr; int sel; int ready; } ctl_t;
    pix_t pix_q[$];
    ctl_t ctl_q[$];
    int   done_q[$];
    int   dir_q[$];

    int checks = 0, errors = 0, cyc = 0;
    bit in_reset = 1'b1;

    int m_screen = 0, m_level = 15, m_target = 0, m_ticks = 0;
    bit m_busy = 1'b0;

    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One input cycle; the reference model advances and pushes what the DUT must show later.
    task automatic drive(input int x, input int y, input bit b, input bit rv, input int rs);
        int addr, idx, t, k, rgb;
        @(posedge vga_clk);
        #1;
        DrawX = 10'(x); DrawY = 10'(y); blank = b; req_valid = rv; req_screen = SEL_W'(rs);
        if (x == 0 && y == SCREEN_H) begin
            if (m_busy) begin
                m_ticks++;
                k = m_ticks;
`ifdef SCREEN_FADE_EN
                if (k <= 15 * FADE_FRAMES) begin
                    m_level = 15 - k / FADE_FRAMES;
                end else if (k == 15 * FADE_FRAMES + 1) begin
                    m_screen = m_target;
                end else begin
                    m_level = k / FADE_FRAMES - (15 * FADE_FRAMES + 1) / FADE_FRAMES;
                    if (m_level >= 15) begin
                        m_level = 15;
                        m_busy = 1'b0;
                        done_q.push_back(cyc + 1);
                    end
                end
`else
                m_screen = m_target;
                m_busy = 1'b0;
                done_q.push_back(cyc + 1);
`endif
            end
        end else if (rv && !m_busy) begin
            t = (rs >= NUM_SCREENS) ? NUM_SCREENS - 1 : rs;
            if (t == m_screen) done_q.push_back(cyc + 1);
            else begin
                m_busy = 1'b1; m_target = t; m_ticks = 0;
            end
        end
        addr = ((x * SRC_W) / SCREEN_W + ((y * SRC_H) / SCREEN_H) * SRC_W) % (1 << ADDR_W);
        ctl_q.push_back('{cyc + 1, addr, m_screen, m_busy ? 0 : 1});
        if (b) begin
            idx = int'(rom_fn(m_screen, addr));
            rgb = (scale(idx % 16, m_level) << 8) | (scale(idx / 16, m_level) << 4)
                | scale((idx % 16) ^ (idx / 16), m_level);
        end else begin
            rgb = 0;
        end
        pix_q.push_back('{cyc + 3, rgb});
    endtask

    // Visible run, then vertical blank with the single frame_tick in its middle.
    task automatic run_frame(input int vis, input int req_at, input int rs);
        int x, y;
        for (int i = 0; i < vis; i++) begin
            x = (i == 0) ? SCREEN_W - 1 : (i == 1) ? 0 : int'($urandom_range(0, SCREEN_W - 1));
            y = (i == 0) ? SCREEN_H - 1 : (i == 1) ? 0 : int'($urandom_range(0, SCREEN_H - 1));
            drive(x, y, ($urandom_range(0, 7) != 0), (i == req_at), rs);
        end
        for (int i = 0; i < 3; i++) drive(int'($urandom_range(0, SCREEN_W - 1)), int'($urandom_range(SCREEN_H + 1, 524)), 1'b0, 1'b0, 0);
        drive(0, SCREEN_H, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) drive(int'($urandom_range(0, SCREEN_W - 1)), int'($urandom_range(SCREEN_H + 1, 524)), 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(posedge vga_clk);
        #1;
        reset_n = 1'b0; in_reset = 1'b1; req_valid = 1'b0;
        pix_q.delete(); ctl_q.delete(); done_q.delete();
        m_busy = 1'b0; m_screen = 0; m_level = 15; m_ticks = 0;
        #1;
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_rom_sel", int'(rom_sel), 0);
        check("rst_rgb", int'({red, green, blue}), 0);
        check("rst_done", int'(done), 0);
        repeat (2) @(posedge vga_clk);
        #1;
        reset_n = 1'b1; in_reset = 1'b0;
        #1;
        check("rst_req_ready", int'(req_ready), 1);
    endtask

    pix_t mp;
    ctl_t mc;
    bit   exp_d;

    always @(negedge vga_clk) begin
        if (!in_reset) begin
            while (ctl_q.size() > 0 && ctl_q[0].due <= cyc) begin
                mc = ctl_q.pop_front();
                check("ctl_due", mc.due, cyc);
                check("rom_addr", int'(rom_addr), mc.addr);
                check("rom_sel", int'(rom_sel), mc.sel);
                check("req_ready", int'(req_ready), mc.ready);
            end
            while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
                mp = pix_q.pop_front();
                check("pix_due", mp.due, cyc);
                check("rgb", int'({red, green, blue}), mp.rgb);
            end
            exp_d = (done_q.size() > 0 && done_q[0] == cyc);
            if (exp_d) void'(done_q.pop_front());
            if (exp_d || done) check("done", int'(done), int'(exp_d));
        end
    end

    initial begin
        int ra, rs;
        dir_q = '{2, 2, 7, 6, 3};
        repeat (2) @(posedge vga_clk);
        #2;
        check("init_rom_addr", int'(rom_addr), 0);
        check("init_rom_sel", int'(rom_sel), 0);
        check("init_rgb", int'({red, green, blue}), 0);
        check("init_done", int'(done), 0);
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1; in_reset = 1'b0;
        #1;
        check("init_req_ready", int'(req_ready), 1);

        drive(320, 240, 1'b1, 1'b0, 0);
        drive(100, 50, 1'b0, 1'b0, 0);
        drive(639, 479, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) drive(0, 500, 1'b0, 1'b0, 0);

        for (int f = 0; f < 300; f++) begin
            ra = int'($urandom_range(2, 7));
            rs = 0;
            if (!m_busy && dir_q.size() > 0) rs = dir_q.pop_front();
            else if ($urandom_range(0, 3) == 0) rs = int'($urandom_range(0, 7));
            else ra = -1;
            run_frame(8 + int'($urandom_range(0, 6)), ra, rs);
        end
        while (m_busy) run_frame(8, -1, 0);

        // abandon a transition with reset, then make sure nothing completes afterwards
        drive(10, 10, 1'b1, 1'b1, (m_screen + 1) % NUM_SCREENS);
`ifdef SCREEN_FADE_EN
        for (int i = 0; i < 5; i++) run_frame(8, -1, 0);
`endif
        drive(20, 20, 1'b1, 1'b0, 0);
        drive(30, 30, 1'b1, 1'b0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) run_frame(10, -1, 0);
        run_frame(10, 3, 1);
        for (int i = 0; i < 100 && m_busy; i++) run_frame(8, -1, 0);
        check("final_model_idle", int'(m_busy), 0);
        run_frame(8, -1, 0);

        repeat (5) @(posedge vga_clk);
        #6;
        check("pix_q_left", pix_q.size(), 0);
        check("ctl_q_left", ctl_q.size(), 0);
        check("done_q_left", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
